// File: rtl/rotsq_pkg.sv
// Shared types, glyph constants and the position-to-digit map for the square rotator.
package rotsq_pkg;

  typedef logic [2:0] pos_t;
  typedef logic [1:0] dsel_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low
  localparam logic [7:0] SEG_UPPER = 8'h9C;
  localparam logic [7:0] SEG_LOWER = 8'hA3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Upper square runs digit 3->0 on pos 0..3; lower square runs digit 0->3 on pos 4..7
  function automatic dsel_t pos_to_digit(input pos_t pos);
    return pos[2] ? dsel_t'(pos[1:0]) : dsel_t'(~pos[1:0]);
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit scan: free-running refresh counter, anode decode and
// registered an/sseg outputs so both change on the same edge.
module seg_scan_mux
  import rotsq_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] digit_seg [4],
  output logic [3:0] an,
  output logic [7:0] sseg
);

  logic [REFRESH_BITS-1:0] refresh;
  dsel_t                   sel;

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so an and sseg are both derived from the same sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      an      <= 4'hF;
      sseg    <= SEG_BLANK;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      an      <= ~(4'b0001 << sel);
      sseg    <= digit_seg[sel];
    end
  end

endmodule

// File: rtl/square_rotator.sv
// Square glyph rotating over 8 positions on a 4-digit active-low 7-seg display.
// Optional build macro SQUARE_ROTATOR_DIR_DP_EN lights dp on the square's digit while cw=1.
module square_rotator
  import rotsq_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int START_POS    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tic,
  input  logic       en,
  input  logic       cw,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  pos_t       pos;
  dsel_t      sq_digit;
  logic [7:0] glyph;
  logic [7:0] digit_seg [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= pos_t'(START_POS);
    end else if (tic && en) begin
      pos <= cw ? pos + 3'd1 : pos - 3'd1;
    end
  end

  assign sq_digit = pos_to_digit(pos);

  // NOTE: every output of this block is assigned a default first, so no path
  // can leave a value held and infer a latch.
  always_comb begin
    glyph = pos[2] ? SEG_LOWER : SEG_UPPER;
`ifdef SQUARE_ROTATOR_DIR_DP_EN
    glyph[7] = ~cw;
`endif
    for (int i = 0; i < 4; i++) begin
      digit_seg[i] = (sq_digit == dsel_t'(i)) ? glyph : SEG_BLANK;
    end
  end

  seg_scan_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .digit_seg(digit_seg),
    .an       (an),
    .sseg     (sseg)
  );

endmodule

// File: tb/tb_square_rotator.sv
// Scoreboard bench for square_rotator (REFRESH_BITS=4): stimulus queues hand-computed
// display frames tagged with the cycle they must appear on; a monitor compares them.
module tb_square_rotator;

  localparam int RB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tic;
  logic       en;
  logic       cw;
  logic [3:0] an;
  logic [7:0] sseg;

  typedef struct {
    string      name;
    int         at;
    logic [3:0] an;
    logic [7:0] sseg;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors     = 0;
  int   miscompares = 0;

  square_rotator #(
    .REFRESH_BITS(RB),
    .START_POS   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tic (tic),
    .en  (en),
    .cw  (cw),
    .an  (an),
    .sseg(sseg)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; after n edges the outputs show digit ((n-1)%16)/4
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.at != cyc) begin
        miscompares++;
        $display("FAIL %s: sample slot %0d missed (now cycle %0d)", e.name, e.at, cyc);
      end else if (an !== e.an || sseg !== e.sseg) begin
        miscompares++;
        $display("FAIL %s: an=%b sseg=%h, expected an=%b sseg=%h",
                 e.name, an, sseg, e.an, e.sseg);
      end
    end
  end

  // Glyph with dp lit while cw=1 when the direction-dp build option is on
  function automatic logic [7:0] dp(input logic [7:0] g);
`ifdef SQUARE_ROTATOR_DIR_DP_EN
    return cw ? (g & 8'h7F) : g;
`else
    return g;
`endif
  endfunction

  task automatic push(input string name, input int at, input logic [3:0] a, input logic [7:0] s);
    exp_t e;
    e.name = name; e.at = at; e.an = a; e.sseg = s;
    sb.push_back(e);
  endtask

  // Expect the frame on the next visit of digit d, then wait until it has been sampled
  task automatic show(input string name, input int d, input logic [3:0] a, input logic [7:0] s);
    int n;
    n = cyc + 2;
    while ((((n - 1) % 16) / 4) != d) n++;
    push(name, n, a, s);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic tic_pulse(input int cycles);
    @(negedge clk);
    tic = 1'b1;
    repeat (cycles) @(negedge clk);
    tic = 1'b0;
  endtask

  typedef struct {
    int         d;
    logic [3:0] a;
    logic [7:0] s;
  } frame_t;

  // Positions 1..7,0 reached by the clockwise sweep
  frame_t sweep [8] = '{
    '{2, 4'b1011, 8'h9C}, '{1, 4'b1101, 8'h9C}, '{0, 4'b1110, 8'h9C}, '{0, 4'b1110, 8'hA3},
    '{1, 4'b1101, 8'hA3}, '{2, 4'b1011, 8'hA3}, '{3, 4'b0111, 8'hA3}, '{3, 4'b0111, 8'h9C}
  };

  initial begin
    rst = 1'b1; tic = 1'b0; en = 1'b0; cw = 1'b0;
    push("reset", 0, 4'hF, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push("first_clk", 1, 4'b1110, 8'hFF);
    show("start_d3", 3, 4'b0111, dp(8'h9C));
    show("start_d2_blank", 2, 4'b1011, 8'hFF);

    en = 1'b1; cw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tic_pulse(1);
      show($sformatf("cw_pos%0d", (k + 1) % 8), sweep[k].d, sweep[k].a, dp(sweep[k].s));
    end

    @(negedge clk);
    cw = 1'b0;
    show("pos0_ccw_dir", 3, 4'b0111, dp(8'h9C));
    tic_pulse(1);
    show("ccw_wrap_pos7", 3, 4'b0111, dp(8'hA3));
    show("pos7_d0_blank", 0, 4'b1110, 8'hFF);

    en = 1'b0; cw = 1'b1;
    repeat (3) begin
      tic_pulse(1);
      repeat (2) @(negedge clk);
    end
    show("freeze_d0", 0, 4'b1110, 8'hFF);
    show("freeze_d1", 1, 4'b1101, 8'hFF);
    show("freeze_d2", 2, 4'b1011, 8'hFF);
    show("freeze_d3", 3, 4'b0111, dp(8'hA3));

    en = 1'b1; cw = 1'b0;
    tic_pulse(1);
    show("ccw_pos6", 2, 4'b1011, dp(8'hA3));

    cw = 1'b1;
    tic_pulse(2);
    show("held_tic_pos0", 3, 4'b0111, dp(8'h9C));

    cw = 1'b0;
    tic_pulse(1);
    repeat (2) @(negedge clk);
    tic_pulse(1);
    show("back_to_pos6", 2, 4'b1011, dp(8'hA3));

    @(posedge clk);
    #1 rst = 1'b1;
    push("midop_reset", 0, 4'hF, 8'hFF);
    @(negedge clk);
    tic = 1'b1;
    @(negedge clk);
    tic = 1'b0;
    rst = 1'b0;
    push("post_reset_clk", 1, 4'b1110, 8'hFF);
    show("post_reset_pos0", 3, 4'b0111, dp(8'h9C));

    repeat (4) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never sampled (slot %0d)", e.name, e.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
